max16_argmax_ctrl: RTL and testbench

Sequencer for the 16-lane signed max tree (`max16`). It accepts a vector of `vec_len` signed elements streamed 16 per beat and tags each lane with its global element index. Each beat passes through the tree, and a running {index, max} is accumulated across beats. The result is returned on a valid/ready port. It sits between the pooling/argmax feature buffer and the activation writeback path, at a throughput of 16 elements per cycle.

---
 rtl/npu_pool_pkg.sv | 22 ++
 rtl/max16.sv | 43 ++++
 rtl/max16_argmax_ctrl.sv | 155 +++++++++++++++
 tb/tb_max16_argmax_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pool_pkg.sv
// Shared definitions for the pooling/argmax datapath: lane count, default
// element/index widths, packed lane word layout and sequencer state encoding.
package npu_pool_pkg;

  localparam int LANES   = 16;
  localparam int DATA_W  = 8;
  localparam int INDEX_W = 16;

  // Packed lane word: {index, data}; data sits at the bottom, index directly above it.
  localparam int WORD_DATA_LSB  = 0;
  localparam int WORD_INDEX_LSB = WORD_DATA_LSB + DATA_W;

  // Most negative element value for the default element width.
  localparam logic signed [DATA_W-1:0] MIN_DATA = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

endpackage

// File: rtl/max16.sv
// Combinational 16-lane signed max tree over packed {index, data} lane words.
// On equal data the lower-numbered input of each pair wins.
module max16
  import npu_pool_pkg::*;
#(
  parameter int Data_Width  = DATA_W,
  parameter int Index_Width = INDEX_W
) (
  input  logic [LANES*(Index_Width+Data_Width)-1:0] lanes,
  output logic [Index_Width+Data_Width-1:0]         max_word
);

  localparam int WORD_W = Index_Width + Data_Width;

  // Pick the word with the larger signed data field; left operand wins ties.
  function automatic logic [WORD_W-1:0] pick(input logic [WORD_W-1:0] a,
                                             input logic [WORD_W-1:0] b);
    if ($signed(a[WORD_DATA_LSB +: Data_Width]) >= $signed(b[WORD_DATA_LSB +: Data_Width])) begin
      pick = a;
    end else begin
      pick = b;
    end
  endfunction

  logic [WORD_W-1:0] l1_s [8];
  logic [WORD_W-1:0] l2_s [4];
  logic [WORD_W-1:0] l3_s [2];

  // Four pairwise reduction levels: 16 -> 8 -> 4 -> 2 -> 1.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      l1_s[k] = pick(lanes[(2*k)*WORD_W +: WORD_W], lanes[(2*k+1)*WORD_W +: WORD_W]);
    end
    for (int k = 0; k < 4; k++) begin
      l2_s[k] = pick(l1_s[2*k], l1_s[2*k+1]);
    end
    for (int k = 0; k < 2; k++) begin
      l3_s[k] = pick(l2_s[2*k], l2_s[2*k+1]);
    end
    max_word = pick(l3_s[0], l3_s[1]);
  end

endmodule

// File: rtl/max16_argmax_ctrl.sv
// Argmax sequencer: streams a vector 16 elements per beat through the max16
// tree, tags lanes with global indices, pads the partial last beat with a copy
// of lane 0, and keeps a running {index, max} that earlier beats win on ties.
module max16_argmax_ctrl
  import npu_pool_pkg::*;
#(
  parameter int Data_Width  = DATA_W,
  parameter int Index_Width = INDEX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [Index_Width-1:0]        vec_len,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*Data_Width-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Data_Width-1:0]         out_max,
  output logic [Index_Width-1:0]        out_index,
  output logic                          busy,
  output logic                          err_len
);

  localparam int WORD_W = Index_Width + Data_Width;
  localparam int CNT_W  = Index_Width + 1;
  localparam int IDX_LSB = WORD_DATA_LSB + Data_Width;

  pool_state_e              state_r;
  logic [Index_Width-1:0]   len_r;
  logic [Index_Width-1:0]   base_r;
  logic                     first_r;
  logic [WORD_W-1:0]        acc_r;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic                     busy_r;
  logic                     err_len_r;

  logic [LANES*WORD_W-1:0]  lanes_s;
  logic [WORD_W-1:0]        tree_s;
  logic                     beat_fire_s;
  logic                     last_beat_s;
  logic                     take_s;

  // Tag lanes with global index; lanes past the vector end carry lane 0's word so pads never win.
  always_comb begin
    lanes_s = {(LANES*WORD_W){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (({1'b0, base_r} + CNT_W'(k)) < {1'b0, len_r}) begin
        lanes_s[k*WORD_W +: WORD_W] = {base_r + Index_Width'(k),
                                       in_data[k*Data_Width +: Data_Width]};
      end else begin
        lanes_s[k*WORD_W +: WORD_W] = {base_r, in_data[Data_Width-1:0]};
      end
    end
  end

  max16 #(
    .Data_Width (Data_Width),
    .Index_Width(Index_Width)
  ) u_max16 (
    .lanes   (lanes_s),
    .max_word(tree_s)
  );

  // Beat handshake, last-beat detection and strict-greater accumulator update decision.
  always_comb begin
    beat_fire_s = in_valid & in_ready_r;
    last_beat_s = (({1'b0, base_r} + CNT_W'(LANES)) >= {1'b0, len_r});
    if (first_r) begin
      take_s = 1'b1;
    end else if ($signed(tree_s[WORD_DATA_LSB +: Data_Width]) >
                 $signed(acc_r[WORD_DATA_LSB +: Data_Width])) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Sequencer FSM with registered handshake/status outputs and the running accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      len_r       <= {Index_Width{1'b0}};
      base_r      <= {Index_Width{1'b0}};
      first_r     <= 1'b0;
      acc_r       <= {WORD_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_len_r   <= 1'b0;
    end else if (abort) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_len_r   <= 1'b0;
    end else begin
      err_len_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (vec_len != {Index_Width{1'b0}}) begin
              len_r      <= vec_len;
              base_r     <= {Index_Width{1'b0}};
              first_r    <= 1'b1;
              state_r    <= ST_RUN;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
            end else begin
              err_len_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (beat_fire_s) begin
            first_r <= 1'b0;
            if (take_s) begin
              acc_r <= tree_s;
            end
            if (last_beat_s) begin
              state_r     <= ST_DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              base_r <= base_r + Index_Width'(LANES);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign err_len   = err_len_r;
  assign out_max   = acc_r[WORD_DATA_LSB +: Data_Width];
  assign out_index = acc_r[IDX_LSB +: Index_Width];

endmodule

// File: tb/tb_max16_argmax_ctrl.sv
// Directed self-checking bench for max16_argmax_ctrl with hand-computed results.
module tb_max16_argmax_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  vec_len;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_max;
  logic [15:0]  out_index;
  logic         busy;
  logic         err_len;

  int n_checks = 0;
  int n_fail   = 0;
  int elems [64];

  always #5 clk = ~clk;

  max16_argmax_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vec_len  (vec_len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_index(out_index),
    .busy     (busy),
    .err_len  (err_len)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat_data(input int b);
    logic [127:0] d;
    int v;
    d = 128'd0;
    for (int k = 0; k < 16; k++) begin
      v = elems[b*16 + k];
      d[k*8 +: 8] = v[7:0];
    end
    return d;
  endfunction

  // Start a vector and stream all its beats; optionally toggle in_valid.
  task automatic send_vec(input int len, input bit toggle);
    int nbeats;
    int b;
    int cyc;
    start   = 1'b1;
    vec_len = len[15:0];
    tick();
    start = 1'b0;
    check_eq("in_ready_after_start", in_ready, 1);
    nbeats = (len + 15) / 16;
    b = 0;
    cyc = 0;
    while (b < nbeats && cyc < 100) begin
      in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      in_data  = beat_data(b);
      tick();
      if (in_valid) b++;
      if (b < nbeats) check_eq("out_valid_early", out_valid, 0);
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("beats_accepted", b, nbeats);
    check_eq("out_valid_rise", out_valid, 1);
  endtask

  // Check the result, optionally stall out_ready (with a stray start), then handshake.
  task automatic finish_vec(input int exp_max, input int exp_idx, input int stall, input bit poke);
    check_eq("out_max", $signed(out_max), exp_max);
    if (exp_idx >= 0) check_eq("out_index", out_index, exp_idx);
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 2) begin
        start   = 1'b1;
        vec_len = 16'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_out_max", $signed(out_max), exp_max);
      if (exp_idx >= 0) check_eq("stall_out_index", out_index, exp_idx);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_hs_busy", busy, 0);
    check_eq("post_hs_out_valid", out_valid, 0);
    check_eq("post_hs_in_ready", in_ready, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_len   = 16'd0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_len", err_len, 0);
    check_eq("rst_out_max", out_max, 0);
    check_eq("rst_out_index", out_index, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // len=16, lane k = k-8 -> 7 at index 15
    for (int i = 0; i < 64; i++) elems[i] = (i < 16) ? i - 8 : 0;
    send_vec(16, 1'b0);
    finish_vec(7, 15, 0, 1'b0);

    // len=40, element 37 = 100, pad lanes 40..47 = 127 -> 100 / 37
    for (int i = 0; i < 64; i++) elems[i] = (i < 40) ? i - 10 : 127;
    elems[37] = 100;
    send_vec(40, 1'b0);
    finish_vec(100, 37, 0, 1'b0);

    // len=5, all -128, pads 127 -> -128 at a valid index
    for (int i = 0; i < 64; i++) elems[i] = (i < 5) ? -128 : 127;
    send_vec(5, 1'b0);
    check_eq("idx_not_pad", (out_index < 16'd5) ? 1 : 0, 1);
    finish_vec(-128, -1, 0, 1'b0);

    // len=32, elements 3 and 20 = 50 -> earlier beat wins: 50 / 3
    for (int i = 0; i < 64; i++) elems[i] = i % 10;
    elems[3]  = 50;
    elems[20] = 50;
    send_vec(32, 1'b0);
    finish_vec(50, 3, 0, 1'b0);

    // Backpressure: toggling in_valid, then out_ready low 5 cycles with a stray start
    for (int i = 0; i < 64; i++) elems[i] = (i < 40) ? i - 10 : 127;
    elems[37] = 100;
    send_vec(40, 1'b1);
    finish_vec(100, 37, 5, 1'b1);

    // Asynchronous reset mid-RUN after one beat of len=48
    for (int i = 0; i < 64; i++) elems[i] = 20 + i;
    start = 1'b1; vec_len = 16'd48; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = beat_data(0); tick(); in_valid = 1'b0;
    check_eq("run_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready", in_ready, 0);
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_out_max", out_max, 0);
    check_eq("arst_out_index", out_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // abort mid-RUN
    start = 1'b1; vec_len = 16'd48; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = beat_data(0); tick(); in_valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_out_valid", out_valid, 0);
    repeat (3) tick();
    check_eq("abort_no_result", out_valid, 0);

    // len=1, data 5 -> 5 / 0
    for (int i = 0; i < 64; i++) elems[i] = 127;
    elems[0] = 5;
    send_vec(1, 1'b0);
    finish_vec(5, 0, 0, 1'b0);

    // len=0 -> one-cycle err_len, never busy
    start = 1'b1; vec_len = 16'd0; tick(); start = 1'b0;
    check_eq("err_len_pulse", err_len, 1);
    check_eq("err_busy", busy, 0);
    tick();
    check_eq("err_len_clear", err_len, 0);
    check_eq("err_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
